gpio_change_capture: RTL and testbench

- Downstream capture stage for the GPIO function block in the UMI GPIO example.
- Samples that block's output bus every clock and detects any change in value.
- Queues each changed value, with an optional timestamp, into a small FIFO.
- The host drains the FIFO over a valid/ready interface, so GPIO readback sees every transition instead of only the latest level.

---
 rtl/gpio_change_capture.sv | 166 ++++++++++++++++
 tb/tb_gpio_change_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_change_capture.sv
// gpio_change_capture: watches a GPIO output bus and queues every value change
// into a small circular FIFO, which the host drains over a valid/ready interface.
// Optional macro GPIO_CAPTURE_TIMESTAMP_EN adds a free-running timestamp counter
// and stores its value with each entry; without it, out_time is tied to 0.
module gpio_change_capture #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int TSW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [TSW-1:0]           out_time,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  localparam int EW = DW + TSW;
`else
  localparam int EW = DW;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_count_q, drop_count_d;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [EW-1:0]   entry_d;
  logic [EW-1:0]   head;
  logic [LW-1:0]   occupancy;
  logic            fifo_full;
  logic            fifo_nonempty;
  logic            push_req;
  logic            do_push;
  logic            do_pop;
  logic            do_drop;

`ifdef GPIO_CAPTURE_TIMESTAMP_EN
  logic [TSW-1:0]  ts_q, ts_d;

  // Free-running timestamp, wraps naturally at all-ones.
  always_comb begin
    ts_d = ts_q + 1'b1;
  end

  // Timestamp register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  // Occupancy and handshake qualifiers; the wrap bit separates full from empty.
  always_comb begin
    occupancy     = wr_ptr_q - rd_ptr_q;
    fifo_nonempty = (wr_ptr_q != rd_ptr_q);
    fifo_full     = (occupancy == LW'(DEPTH));
    head          = mem_q[rd_ptr_q[AW-1:0]];
    do_pop        = fifo_nonempty && out_ready;
    // Only a running, enabled capture can see a change; ARM establishes the baseline.
    push_req      = (state_q == ST_RUN) && en && (in_data != prev_q);
    // A pop in the same cycle frees the slot a full FIFO needs.
    do_push       = push_req && (!fifo_full || do_pop);
    do_drop       = push_req && fifo_full && !do_pop;
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
    entry_d       = {in_data, ts_q};
`else
    entry_d       = in_data;
`endif
  end

  // Next-state logic for the enable/arm/run sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_ARM;
      ST_ARM:  state_d = en ? ST_RUN : ST_IDLE;
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: baseline tracking, pointers, drop accounting.
  always_comb begin
    prev_d       = prev_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    // Baseline is loaded unconditionally in ARM, and follows the bus while running.
    if (state_q == ST_ARM || (state_q == ST_RUN && en)) prev_d = in_data;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end

    // Clear takes priority over a drop in the same cycle.
    if (clear) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // FIFO storage; contents need no reset since outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_d;
  end

  // Outputs: head entry is shown combinationally, zeroed when the FIFO is empty.
  always_comb begin
    out_valid  = fifo_nonempty;
    overflow   = overflow_q;
    drop_count = drop_count_q;
    level      = occupancy;
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
    out_data   = fifo_nonempty ? head[EW-1:TSW] : '0;
    out_time   = fifo_nonempty ? head[TSW-1:0]  : '0;
`else
    out_data   = fifo_nonempty ? head : '0;
    out_time   = '0;
`endif
  end

endmodule

// File: tb/tb_gpio_change_capture.sv
// Directed testbench for gpio_change_capture (DW=32, DEPTH=8, TSW=4).
module tb_gpio_change_capture;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int TSW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            clear = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [TSW-1:0]  out_time;
  logic            overflow;
  logic [15:0]     drop_count;
  logic [3:0]      level;

  int n_checks = 0;
  int n_errors = 0;

  // Reference for the free-running counter: edges since reset, 4 bits.
  logic [TSW-1:0]  edge_cnt;

  gpio_change_capture #(.DW(DW), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_time(out_time), .overflow(overflow), .drop_count(drop_count),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= '0;
    else     edge_cnt <= edge_cnt + 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected timestamp: counter value seen by the most recent edge.
  function automatic logic [TSW-1:0] ts_exp(input logic [TSW-1:0] v);
`ifdef GPIO_CAPTURE_TIMESTAMP_EN
    return v;
`else
    return '0 & v;
`endif
  endfunction

  logic [TSW-1:0] t1;
  int             guard;

  initial begin
    // Reset state
    #23;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_time", out_time, 0);
    rst = 1'b0;
    tick();

    // Constant input: ARM pushes nothing, nothing is ever queued
    in_data = 32'h5A;
    en = 1'b1;
    tick();  // -> ARM
    tick();  // ARM loads baseline -> RUN
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("hold_valid", out_valid, 0);
    end
    $display("txn hold: 20 cycles constant input, level=%0d", level);

    // Re-enable with baseline 0, then two back-to-back changes
    en = 1'b0;
    tick();  // -> IDLE
    in_data = 32'h0;
    en = 1'b1;
    tick();  // -> ARM
    tick();  // baseline 0 -> RUN
    tick();
    check_eq("base_valid", out_valid, 0);
    out_ready = 1'b1;
    in_data = 32'h1;
    tick();  // push 1
    check_eq("chg1_valid", out_valid, 1);
    check_eq("chg1_data", out_data, 32'h1);
    t1 = out_time;
    check_eq("chg1_time", out_time, ts_exp(edge_cnt - 1'b1));
    $display("txn change: data=%0h time=%0h", out_data, out_time);
    in_data = 32'h2;
    tick();  // pop 1, push 2
    check_eq("chg2_valid", out_valid, 1);
    check_eq("chg2_data", out_data, 32'h2);
    check_eq("chg2_time", out_time, ts_exp(t1 + 1'b1));
    $display("txn change: data=%0h time=%0h", out_data, out_time);
    tick();  // pop 2
    check_eq("chg_empty", out_valid, 0);

    // Drop enable, change input, re-enable: no spurious event
    en = 1'b0;
    tick();
    in_data = 32'h7;
    tick();
    en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_eq("reen_valid", out_valid, 0);
    check_eq("reen_level", level, 0);
    $display("txn reenable: level=%0d", level);

    // Overflow: 10 changes into 8 slots
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'd100 + i;
      tick();
    end
    in_data = 32'd109;
    check_eq("ovf_level", level, 8);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_drops", drop_count, 2);
    tick();
    tick();
    check_eq("stall_data", out_data, 32'd100);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_data", out_data, 32'd100 + i);
      $display("txn drain: data=%0d", out_data);
      tick();
    end
    check_eq("drain_empty", out_valid, 0);
    check_eq("drain_sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_ovf", overflow, 0);
    check_eq("clr_drop", drop_count, 0);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'd200 + i;
      tick();
    end
    check_eq("full_level", level, 8);
    out_ready = 1'b1;
    in_data = 32'd208;
    tick();
    check_eq("pp_level", level, 8);
    check_eq("pp_drop", drop_count, 0);
    check_eq("pp_ovf", overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      check_eq("pp_data", out_data, 32'd200 + i);
      $display("txn drain: data=%0d", out_data);
      tick();
    end
    check_eq("pp_empty", out_valid, 0);

    // Clear coincident with a drop
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'd300 + i;
      tick();
    end
    in_data = 32'd308;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("race_ovf", overflow, 0);
    check_eq("race_drop", drop_count, 0);
    check_eq("race_level", level, 8);
    in_data = 32'd309;
    tick();
    check_eq("drop_ovf", overflow, 1);
    check_eq("drop_cnt", drop_count, 1);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    check_eq("pre_rst_level", level, 5);
    check_eq("pre_rst_data", out_data, 32'd303);

    // Asynchronous reset mid-cycle flushes immediately
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_level", level, 0);
    check_eq("arst_ovf", overflow, 0);
    check_eq("arst_drop", drop_count, 0);
    $display("txn async reset: level=%0d valid=%0d", level, out_valid);
    #3;
    rst = 1'b0;

    // Timestamp wrap: pushes at counter 15 and 0
    in_data = 32'h0;
    en = 1'b1;
    tick();
    tick();
    tick();
    guard = 0;
    while (edge_cnt != 4'd15 && guard < 40) begin
      tick();
      guard++;
    end
    check_eq("wrap_reach", (guard < 40), 1);
    in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    check_eq("wrap_level", level, 2);
    check_eq("wrap_d0", out_data, 32'hA);
    check_eq("wrap_t0", out_time, ts_exp(4'd15));
    $display("txn wrap: data=%0h time=%0h", out_data, out_time);
    out_ready = 1'b1;
    tick();
    check_eq("wrap_d1", out_data, 32'hB);
    check_eq("wrap_t1", out_time, ts_exp(4'd0));
    $display("txn wrap: data=%0h time=%0h", out_data, out_time);
    tick();
    check_eq("wrap_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
